// File: rtl/stopwatch_preset_loader_pkg.sv
// Shared types and per-digit limits for the stopwatch preset entry path.
`default_nettype none

package stopwatch_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        LOAD = 2'd2
    } preset_state_t;

    // Index 0 is digit5 (minutes tens), index 5 is digit0 (hundredths units).
    localparam digit_t DIGIT_MAX [6] = '{4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    function automatic digit_t digit_max(input int unsigned n);
        return DIGIT_MAX[5 - n];
    endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_preset_loader_if.sv
// Preset load bus: six BCD digits offered to the datapath over valid/ready.
`default_nettype none

interface stopwatch_preset_loader_if;
    import stopwatch_pkg::*;

    logic   load_valid;
    logic   load_ready;
    digit_t digit5;
    digit_t digit4;
    digit_t digit3;
    digit_t digit2;
    digit_t digit1;
    digit_t digit0;

    modport master (
        output load_valid,
        output digit5, digit4, digit3, digit2, digit1, digit0,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  digit5, digit4, digit3, digit2, digit1, digit0,
        output load_ready
    );

endinterface

`default_nettype wire

// File: rtl/stopwatch_preset_loader_key_debouncer.sv
// Key conditioner: 2-FF synchronizer, tick-sampled stability counter, level and press pulse.
`default_nettype none

module key_debouncer #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic tick,
    input  wire logic key_raw,
    output logic      level,
    output logic      press
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], key_raw};
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (tick) begin
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    level_d = sync_q[1];
                    cnt_d   = '0;
                    press_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                // A sample matching the accepted level restarts the stability run.
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_preset_loader.sv
// Button-driven MM:SS:cc preset editor feeding the datapath parallel-load port.
// Optional auto-repeat on a held increment key: PRESET_AUTOREPEAT_EN.
`default_nettype none

module stopwatch_preset_loader
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  tick,
    input  wire logic                  key_next,
    input  wire logic                  key_inc,
    input  wire logic                  key_load,
    output logic [5:0]                 cursor,
    stopwatch_preset_loader_if.master  load_if
);

    logic lvl_next, lvl_inc, lvl_load;
    logic press_next, press_inc, press_load;
    logic rep_fire;

    key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_next (
        .clk(clk), .rst(rst), .tick(tick), .key_raw(key_next), .level(lvl_next), .press(press_next)
    );
    key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_inc (
        .clk(clk), .rst(rst), .tick(tick), .key_raw(key_inc), .level(lvl_inc), .press(press_inc)
    );
    key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_load (
        .clk(clk), .rst(rst), .tick(tick), .key_raw(key_load), .level(lvl_load), .press(press_load)
    );

    preset_state_t state_q, state_d;
    logic [5:0]    cursor_q, cursor_d;
    digit_t        dig_q [6];
    digit_t        dig_d [6];
    logic          inc_now;

`ifdef PRESET_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d;
    logic          rep_clear;
    logic          unused_levels;

    // Any cursor move or state change in EDIT is caused by a next/load press.
    assign rep_clear = !(state_q == EDIT && lvl_inc) || press_next || press_load;

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (rep_clear) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (tick) begin
            if (rep_cnt_q == (rep_phase_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign unused_levels = lvl_next ^ lvl_load;
`else
    logic        unused_levels;
    logic [31:0] unused_repeat_cfg;

    assign rep_fire          = 1'b0;
    assign unused_levels     = lvl_next ^ lvl_inc ^ lvl_load;
    assign unused_repeat_cfg = 32'(REPEAT_DELAY + REPEAT_RATE);
`endif

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        dig_d    = dig_q;
        inc_now  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_next) begin
                    state_d  = EDIT;
                    cursor_d = 6'b100000;
                end
            end
            EDIT: begin
                if (press_load) begin
                    state_d = LOAD;
                end else if (press_next) begin
                    cursor_d = {cursor_q[0], cursor_q[5:1]};
                end else if (press_inc || rep_fire) begin
                    inc_now = 1'b1;
                end
            end
            LOAD: begin
                if (load_if.load_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (inc_now) begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (cursor_q[i]) begin
                    dig_d[i] = (dig_q[i] >= digit_max(i)) ? 4'd0 : dig_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            dig_q    <= '{default: 4'd0};
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            dig_q    <= dig_d;
        end
    end

    assign cursor             = (state_q == EDIT) ? cursor_q : 6'b000000;
    assign load_if.load_valid = (state_q == LOAD);
    assign load_if.digit5     = dig_q[5];
    assign load_if.digit4     = dig_q[4];
    assign load_if.digit3     = dig_q[3];
    assign load_if.digit2     = dig_q[2];
    assign load_if.digit1     = dig_q[1];
    assign load_if.digit0     = dig_q[0];

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_preset_loader.sv
// Scoreboard bench: stimulus pushes expected output snapshots, a monitor pops one per observed change.
`default_nettype none

module tb_stopwatch_preset_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       key_next, key_inc, key_load;
    logic [5:0] cursor;

    stopwatch_preset_loader_if lif();

    stopwatch_preset_loader #(
        .DEBOUNCE_TICKS(3),
        .REPEAT_DELAY  (50),
        .REPEAT_RATE   (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .key_next(key_next),
        .key_inc (key_inc),
        .key_load(key_load),
        .cursor  (cursor),
        .load_if (lif)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    logic [30:0] exp_q[$];

    logic [3:0] m_dig [6];
    logic [5:0] m_cur;
    int         m_state;

    function automatic logic [30:0] observed();
        return {lif.digit5, lif.digit4, lif.digit3, lif.digit2, lif.digit1, lif.digit0,
                cursor, lif.load_valid};
    endfunction

    function automatic logic [30:0] model_snap();
        logic [5:0] c;
        c = (m_state == 1) ? m_cur : 6'b0;
        return {m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0], c, m_state == 2};
    endfunction

    function automatic int mx(input int i);
        return (i == 5 || i == 3) ? 5 : 9;
    endfunction

    function automatic int cur_idx();
        for (int i = 0; i < 6; i++) if (m_cur[i]) return i;
        return 0;
    endfunction

    initial begin
        logic [30:0] last;
        logic [30:0] e;
        wait (mon_en);
        last = observed();
        forever begin
            @(negedge clk);
            if (observed() != last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h required no change from %h", observed(), last);
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        errors++;
                        $display("FAIL snapshot: got %h required %h", observed(), e);
                    end
                end
                last = observed();
            end
        end
    end

    task automatic tap(input bit n, input bit i, input bit l);
        @(posedge clk);
        #1;
        key_next = n; key_inc = i; key_load = l;
        repeat (24) @(posedge clk);
        #1;
        key_next = 1'b0; key_inc = 1'b0; key_load = 1'b0;
        repeat (24) @(posedge clk);
    endtask

    task automatic do_next();
        if (m_state == 0) begin
            m_state = 1;
            m_cur   = 6'b100000;
            exp_q.push_back(model_snap());
        end else if (m_state == 1) begin
            m_cur = {m_cur[0], m_cur[5:1]};
            exp_q.push_back(model_snap());
        end
        tap(1'b1, 1'b0, 1'b0);
    endtask

    task automatic model_inc();
        int k;
        k = cur_idx();
        m_dig[k] = (int'(m_dig[k]) == mx(k)) ? 4'd0 : m_dig[k] + 4'd1;
        exp_q.push_back(model_snap());
    endtask

    task automatic do_inc();
        if (m_state == 1) model_inc();
        tap(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_load();
        if (m_state == 1) begin
            m_state = 2;
            exp_q.push_back(model_snap());
        end
        tap(1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_digit(input int i, input int v);
        while (!m_cur[i]) do_next();
        while (int'(m_dig[i]) != v) do_inc();
    endtask

    task automatic hold_inc();
        int n;
`ifdef PRESET_AUTOREPEAT_EN
        n = 5;
`else
        n = 1;
`endif
        for (int k = 0; k < n; k++) model_inc();
        @(posedge clk);
        #1 key_inc = 1'b1;
        repeat (88 * 4) @(posedge clk);
        #1 key_inc = 1'b0;
        repeat (24) @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        key_next = 1'b0; key_inc = 1'b0; key_load = 1'b0;
        lif.load_ready = 1'b0;
        for (int i = 0; i < 6; i++) m_dig[i] = 4'd0;
        m_cur = 6'b0;
        m_state = 0;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 31'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", observed(), 31'd0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Short glitch on key_next must not be accepted.
        #1 key_next = 1'b1;
        repeat (8) @(posedge clk);
        #1 key_next = 1'b0;
        repeat (40) @(posedge clk);

        do_next();
        for (int k = 0; k < 7; k++) do_inc();
        for (int k = 0; k < 6; k++) do_next();
        do_next();
        for (int k = 0; k < 10; k++) do_inc();
        hold_inc();

        // Coincident next and inc: only the cursor moves.
        m_cur = {m_cur[0], m_cur[5:1]};
        exp_q.push_back(model_snap());
        tap(1'b1, 1'b1, 1'b0);

        set_digit(3, 5);
        set_digit(2, 9);
        set_digit(1, 9);
        set_digit(0, 9);
        set_digit(5, 5);
        set_digit(4, 9);

        do_load();
        checks++;
        if (lif.load_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_valid_held: got %b required 1", lif.load_valid);
        end
        do_inc();
        do_next();

        m_state = 0;
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1 lif.load_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Ready held high while idle; re-entry resumes the stored digits.
        do_next();
        #1 lif.load_ready = 1'b0;
        do_load();

        for (int i = 0; i < 6; i++) m_dig[i] = 4'd0;
        m_state = 0;
        m_cur = 6'b0;
        exp_q.push_back(model_snap());
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (observed() !== 31'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", observed(), 31'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected: got %0d left required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
